// File: rtl/dense_layer_seq_pkg.sv
// Shared fixed-point definitions for the dense layer family.
// Holds the default word type, the Q-format constants, the layer FSM
// state encoding and the mul/add helpers used by every MAC lane.
// Helpers operate on 32-bit sign-extended operands, so callers must keep
// BITSIZE <= 32 and truncate the result back to their own word width.
package dense_layer_seq_pkg;

  localparam int unsigned BITSIZE_DEF = 20;
  localparam int unsigned FRAC_DEF    = 10;
  localparam int unsigned HELPER_W    = 32;
  localparam int unsigned ONE         = 1 << FRAC_DEF;

  typedef logic signed [BITSIZE_DEF-1:0] fix_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Full-width signed product, arithmetic shift by frac; caller keeps the low bits.
  function automatic logic signed [2*HELPER_W-1:0] fx_mul(
    input logic signed [HELPER_W-1:0] a,
    input logic signed [HELPER_W-1:0] b,
    input int unsigned                frac
  );
    logic signed [2*HELPER_W-1:0] p;
    p = (2*HELPER_W)'(a) * (2*HELPER_W)'(b);
    return p >>> frac;
  endfunction

  // Two's complement add; low bits of the result equal the wrapped narrow sum.
  function automatic logic signed [HELPER_W-1:0] fx_add(
    input logic signed [HELPER_W-1:0] a,
    input logic signed [HELPER_W-1:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One output lane of the dense layer: multiplier, product register,
// accumulator, activation and held output register.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   load           acc <- bias
//   prod_en        prod <- mul(x_j, w_jk)
//   acc_en         acc <- acc + prod
//   fin            y <- act(acc + prod)
//   x_j, w_jk      current input element and weight for this lane
//   bias           lane bias
//   y              registered lane result
// Build option: DENSE_RELU_EN selects ReLU activation, otherwise identity.
module dense_mac_lane
  import dense_layer_seq_pkg::*;
#(
  parameter int unsigned BITSIZE = 20,
  parameter int unsigned FRAC    = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic                      prod_en,
  input  logic                      acc_en,
  input  logic                      fin,
  input  logic signed [BITSIZE-1:0] x_j,
  input  logic signed [BITSIZE-1:0] w_jk,
  input  logic signed [BITSIZE-1:0] bias,
  output logic signed [BITSIZE-1:0] y
);

  logic signed [BITSIZE-1:0] prod;
  logic signed [BITSIZE-1:0] acc;
  logic signed [BITSIZE-1:0] mul_c;
  logic signed [BITSIZE-1:0] sum_c;
  logic signed [BITSIZE-1:0] act_c;

  // Truncated, wrapped Q-format product and running sum.
  assign mul_c = BITSIZE'(fx_mul(HELPER_W'(x_j), HELPER_W'(w_jk), FRAC));
  assign sum_c = BITSIZE'(fx_add(HELPER_W'(acc), HELPER_W'(prod)));

`ifdef DENSE_RELU_EN
  assign act_c = sum_c[BITSIZE-1] ? '0 : sum_c;
`else
  assign act_c = sum_c;
`endif

  // Lane datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod <= '0;
      acc  <= '0;
      y    <= '0;
    end else begin
      if (load) begin
        acc <= bias;
      end else if (acc_en) begin
        acc <= sum_c;
      end
      if (prod_en) begin
        prod <= mul_c;
      end
      if (fin) begin
        y <= act_c;
      end
    end
  end

endmodule

// File: rtl/dense_layer_seq.sv
// Sequential fixed-point fully-connected layer y = act(W^T x + b).
// One input element per cycle, all N_OUT lanes in parallel.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   start, ready   request handshake; accepted on start && ready
//   done           one-cycle pulse when y is updated
//   x, w, b        packed input vector, weight matrix, biases (held by driver)
//   y              packed registered result, held until next done
// Build option: DENSE_RELU_EN enables ReLU in every lane.
module dense_layer_seq
  import dense_layer_seq_pkg::*;
#(
  parameter int unsigned BITSIZE = 20,
  parameter int unsigned FRAC    = 10,
  parameter int unsigned N_IN    = 10,
  parameter int unsigned N_OUT   = 6
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  output logic                            ready,
  output logic                            done,
  input  logic [BITSIZE*N_IN-1:0]         x,
  input  logic [BITSIZE*N_OUT*N_IN-1:0]   w,
  input  logic [BITSIZE*N_OUT-1:0]        b,
  output logic [BITSIZE*N_OUT-1:0]        y
);

  localparam int unsigned JW = $clog2(N_IN);
  localparam logic [JW-1:0] J_LAST = JW'(N_IN - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_MAC  = ST_MAC;
  localparam logic [1:0] S_FIN  = ST_FIN;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [JW-1:0]     j;
  logic              load_c;
  logic              prod_en_c;
  logic              acc_en_c;
  logic              fin_c;
  logic [BITSIZE-1:0] x_j_c;

  // Next-state and lane strobes.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    prod_en_c  = 1'b0;
    acc_en_c   = 1'b0;
    fin_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = S_MAC;
        end
      end
      S_MAC: begin
        prod_en_c = 1'b1;
        // First MAC edge only fills prod; acc still holds the bias.
        acc_en_c  = (j != '0);
        if (j == J_LAST) begin
          state_next = S_FIN;
        end
      end
      S_FIN: begin
        fin_c      = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next == S_IDLE);
      done  <= fin_c;
    end
  end

  // Input element index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      j <= '0;
    end else if (load_c) begin
      j <= '0;
    end else if (prod_en_c) begin
      j <= j + JW'(1);
    end
  end

  assign x_j_c = x[BITSIZE*j +: BITSIZE];

  // Parallel output lanes.
  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    logic [BITSIZE-1:0] w_jk_c;
    assign w_jk_c = w[BITSIZE*N_OUT*j + BITSIZE*k +: BITSIZE];

    dense_mac_lane #(
      .BITSIZE (BITSIZE),
      .FRAC    (FRAC)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load_c),
      .prod_en (prod_en_c),
      .acc_en  (acc_en_c),
      .fin     (fin_c),
      .x_j     (x_j_c),
      .w_jk    (w_jk_c),
      .bias    (b[BITSIZE*k +: BITSIZE]),
      .y       (y[BITSIZE*k +: BITSIZE])
    );
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Self-checking bench for dense_layer_seq against an arithmetic reference model.
module tb_dense_layer_seq;

  localparam int unsigned BITSIZE = 20;
  localparam int unsigned FRAC    = 10;
  localparam int unsigned N_IN    = 10;
  localparam int unsigned N_OUT   = 6;
  localparam int unsigned B       = BITSIZE;

  logic                          clk = 1'b0;
  logic                          reset_n;
  logic                          start;
  logic                          ready;
  logic                          done;
  logic [B*N_IN-1:0]             x;
  logic [B*N_OUT*N_IN-1:0]       w;
  logic [B*N_OUT-1:0]            b;
  logic [B*N_OUT-1:0]            y;

  logic signed [B-1:0] xa [N_IN];
  logic signed [B-1:0] wa [N_IN][N_OUT];
  logic signed [B-1:0] ba [N_OUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dense_layer_seq #(
    .BITSIZE (BITSIZE),
    .FRAC    (FRAC),
    .N_IN    (N_IN),
    .N_OUT   (N_OUT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .ready   (ready),
    .done    (done),
    .x       (x),
    .w       (w),
    .b       (b),
    .y       (y)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pack_bus();
    for (int j = 0; j < N_IN; j++) begin
      x[B*j +: B] = xa[j];
      for (int k = 0; k < N_OUT; k++) w[B*N_OUT*j + B*k +: B] = wa[j][k];
    end
    for (int k = 0; k < N_OUT; k++) b[B*k +: B] = ba[k];
  endtask

  task automatic set_uniform(input logic [B-1:0] xv, input logic [B-1:0] wv, input logic [B-1:0] bv);
    for (int j = 0; j < N_IN; j++) begin
      xa[j] = xv;
      for (int k = 0; k < N_OUT; k++) wa[j][k] = wv;
    end
    for (int k = 0; k < N_OUT; k++) ba[k] = bv;
    pack_bus();
  endtask

  task automatic set_random();
    for (int j = 0; j < N_IN; j++) begin
      xa[j] = B'($urandom);
      for (int k = 0; k < N_OUT; k++) wa[j][k] = B'($urandom);
    end
    for (int k = 0; k < N_OUT; k++) ba[k] = B'($urandom);
    pack_bus();
  endtask

  function automatic longint wrap(input longint v);
    logic [B-1:0] t;
    t = v[B-1:0];
    return longint'(signed'(t));
  endfunction

  // Reference: wrapped sum of floor(x*w / 2^FRAC) plus bias, then activation.
  function automatic logic [B-1:0] model_lane(input int k);
    longint acc;
    longint p;
    acc = longint'(ba[k]);
    for (int j = 0; j < N_IN; j++) begin
      p   = (longint'(xa[j]) * longint'(wa[j][k])) >>> FRAC;
      acc = wrap(acc + p);
    end
`ifdef DENSE_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return B'(acc);
  endfunction

  function automatic logic [B-1:0] lane_y(input int k);
    return y[B*k +: B];
  endfunction

  task automatic check_lanes(input string tag);
    for (int k = 0; k < N_OUT; k++)
      check($sformatf("%s_y%0d", tag, k), 64'(lane_y(k)), 64'(model_lane(k)));
  endtask

  // One start/done transaction with latency, busy and result checks.
  task automatic run_op(input string tag);
    int lat;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (ready) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, 64'(lat), 64'(N_IN + 1));
    check({tag, "_ready_low_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_ready_at_done"}, 64'(ready), 64'd1);
    check_lanes(tag);
    @(posedge clk);
    #1 check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit saw_done;
    bit hold_ok;
    int ndone;
    int last_done;
    logic [B*N_OUT-1:0] prev_y;

    reset_n = 1'b0;
    start   = 1'b0;
    set_uniform('0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    for (int k = 0; k < N_OUT; k++) check($sformatf("rst_y%0d", k), 64'(lane_y(k)), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Unity inputs and weights: 10.0 per lane.
    set_uniform(20'h00400, 20'h00400, 20'h00000);
    run_op("ones");
    for (int k = 0; k < N_OUT; k++) check($sformatf("ones_const%0d", k), 64'(lane_y(k)), 64'h02800);

    // Negative weights: -5.0, clamped by ReLU when enabled.
    set_uniform(20'h00400, 20'hFFE00, 20'h00000);
    run_op("neg");
`ifdef DENSE_RELU_EN
    check("neg_const", 64'(lane_y(0)), 64'h00000);
`else
    check("neg_const", 64'(lane_y(0)), 64'hFEC00);
`endif

    // Bias only.
    set_uniform(20'h00400, 20'h00000, 20'h00000);
    for (int k = 0; k < N_OUT; k++) ba[k] = B'(k << FRAC);
    pack_bus();
    run_op("bias");
    for (int k = 0; k < N_OUT; k++) check($sformatf("bias_const%0d", k), 64'(lane_y(k)), 64'(k << FRAC));

    // Overflow wraps to -512.0 (ReLU build clamps it).
    set_uniform(20'h04000, 20'h04000, 20'h00000);
    run_op("ovf");
`ifdef DENSE_RELU_EN
    check("ovf_const", 64'(lane_y(0)), 64'h00000);
`else
    check("ovf_const", 64'(lane_y(0)), 64'h80000);
`endif

    // Reset mid-run aborts the operation.
    set_uniform(20'h00400, 20'h00400, 20'h00000);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    for (int k = 0; k < N_OUT; k++) check($sformatf("abort_y%0d", k), 64'(lane_y(k)), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_ready", 64'(ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1 if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    run_op("restart");
    check("restart_const", 64'(lane_y(0)), 64'h02800);

    // Random transactions.
    for (int r = 0; r < 6; r++) begin
      set_random();
      run_op($sformatf("rand%0d", r));
    end

    // Start held high: back-to-back runs, new operands loaded at each done.
    set_random();
    @(negedge clk);
    start = 1'b1;
    ndone = 0;
    last_done = 0;
    hold_ok = 1'b1;
    prev_y = y;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (ndone > 0) check($sformatf("b2b_interval%0d", ndone), 64'(c - last_done), 64'(N_IN + 2));
        check_lanes($sformatf("b2b%0d", ndone));
        ndone++;
        last_done = c;
        set_random();
        prev_y = y;
      end else if (y !== prev_y) begin
        hold_ok = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_hold", 64'(hold_ok), 64'd1);
    check("b2b_count", 64'(ndone >= 5), 64'd1);
    repeat (15) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_layer_seq.md
# dense_layer_seq

Parametrised, sequential fixed-point fully-connected layer: y = act(Wᵀx + b) for N_IN inputs and N_OUT outputs. All N_OUT output lanes run in parallel, and inputs are consumed one per cycle. Successor to the fixed 10×6 encoder stage in the encoder/decoder chain, and drops in between adjacent layers. Adds these over the fixed stage:
- start/ready/done handshake
- registered products
- a held output register
- optional ReLU

## Interface
Parameters:
- BITSIZE, 20, word width of x, w, b, y (signed two's complement)
- FRAC, 10, fractional bits (Q(BITSIZE-FRAC).FRAC); 1.0 = 2^FRAC
- N_IN, 10, input vector length (≥2)
- N_OUT, 6, output vector length / parallel lanes (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted when start && ready at a rising edge
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse: y updated
- x  in  BITSIZE*N_IN  element j at [BITSIZE*j +: BITSIZE]
- w  in  BITSIZE*N_OUT*N_IN  w[j][k] at [BITSIZE*N_OUT*j + BITSIZE*k +: BITSIZE]
- b  in  BITSIZE*N_OUT  bias k at [BITSIZE*k +: BITSIZE]
- y  out  BITSIZE*N_OUT  registered result, held until next done

## Operation
- x, w and b are not captured. The driver holds them stable from the accept edge until done.
- FSM states:
  - IDLE: ready=1. Accept → MAC, with j←0 and acc[k]←b[k].
  - MAC: Each edge, prod[k] ← mul(x[j], w[j][k]) and j←j+1. From the second MAC edge onward, acc[k] ← acc[k]+prod[k]. When j==N_IN-1, go to FIN.
  - FIN: One edge. y[k] ← act(acc[k]+prod[k]), done←1, go to IDLE.
- mul: full 2·BITSIZE signed product, arithmetic shift right by FRAC, low BITSIZE bits kept (truncation toward −∞, wrap on overflow).
- add: BITSIZE-bit two's complement, wraps with no saturation.
- j counter width is $clog2(N_IN).
- A start arriving while busy (MAC/FIN) is ignored; no queueing.

## Timing
- Reset values: ready=1, done=0, y=0. acc, prod, j and state are cleared; state is IDLE.
- Latency: accept edge E0 → y and done valid after edge E(N_IN+1).
  - With N_IN=10, done is high in the cycle following the 11th edge after E0.
- done is a one-cycle pulse. ready is already high in the done cycle, so a start in that cycle is accepted (back-to-back throughput: one result per N_IN+2 cycles).
- y changes only on the FIN edge.
- Reset asserted mid-operation aborts immediately, with all state at reset values and no done. Reset deassertion is synchronous to clk.

## Configuration
- DENSE_RELU_EN defined: act(v) = (v<0) ? 0 : v, applied per lane at the FIN edge.
- DENSE_RELU_EN undefined: act is identity; y is the raw wrapped sum.
- Latency is identical in both builds.

## Structure
- Shared package holds:
  - fixed-point type of BITSIZE bits
  - FRAC default and the ONE constant (1<<FRAC)
  - FSM state enum (IDLE, MAC, FIN)
  - mul/add helper functions, shared by all layers
- One sub-module, dense_mac_lane, instantiated N_OUT times. It contains the multiplier, the prod register, the acc register, the activation and the y register. It is controlled by shared load/acc/fin strobes from the top-level FSM.

## Test plan
- Defaults: x[j]=1.0 (0x00400), all w=1.0, b=0; start.
  - Every y[k]=0x02800 (10.0).
  - done occurs exactly 11 edges after accept; ready is low in between.
- x[j]=1.0, all w=−0.5 (0xFFE00), b=0.
  - Without DENSE_RELU_EN: y[k]=0xFEC00 (−5.0).
  - With DENSE_RELU_EN: y[k]=0.
- w=0, b[k]=k·1.0.
  - y[k]=k<<10.
  - Independently, overflow: x=16.0, w=16.0, b=0 gives y=0x80000 (wrapped −512.0).
- reset_n pulsed low 5 cycles after accept.
  - y=0, done never pulses, ready=1.
  - Restart with the first scenario's stimulus gives the correct 0x02800 result.
- Start held high continuously.
  - Mid-run starts are ignored.
  - A new run is accepted on each done cycle, giving a done every 12 cycles (N_IN+2).
  - y holds the previous result between dones.
